// File: rtl/div_unit_65.sv
// Multicycle signed 32-bit restoring divider: 32 shift/subtract steps on a 65-bit {rem, quot} reg.
// Optional macro DIV_EARLY_OUT_EN: zero dividend or divisor skips straight to DONE.
module div_unit_65 (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_div,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [64:0] aq_q;
  logic [32:0] divisor_q;
  logic        sign_q;
  logic        dz_q;
  logic [4:0]  count_q;
  logic [31:0] result_q;
  logic        exc_q;
  logic        rdy_q;

  logic [31:0] abs_a;
  logic [32:0] abs_b;
  logic [64:0] aq_sh;
  logic [32:0] diff;
  logic [64:0] aq_d;
  logic [31:0] quot;
  logic        early_out;

  always_comb begin
    abs_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    abs_b = {1'b0, (data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB)};
    aq_sh = aq_q << 1;
    diff  = aq_sh[64:32] - divisor_q;
    aq_d  = aq_sh;
    // Non-negative trial remainder: keep it and shift in a quotient 1; otherwise restore.
    if (!diff[32]) begin
      aq_d[64:32] = diff;
      aq_d[0]     = 1'b1;
    end
    quot = sign_q ? (~aq_q[31:0] + 32'd1) : aq_q[31:0];
`ifdef DIV_EARLY_OUT_EN
    early_out = (data_operandA == 32'd0) || (data_operandB == 32'd0);
`else
    early_out = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      aq_q      <= '0;
      divisor_q <= '0;
      sign_q    <= 1'b0;
      dz_q      <= 1'b0;
      count_q   <= '0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      // A start always wins, aborting any operation in flight without a ready pulse.
      if (ctrl_div) begin
        aq_q      <= {33'd0, abs_a};
        divisor_q <= abs_b;
        sign_q    <= data_operandA[31] ^ data_operandB[31];
        dz_q      <= (data_operandB == 32'd0);
        count_q   <= '0;
        state_q   <= early_out ? StDone : StRun;
      end else begin
        unique case (state_q)
          StIdle: ;
          StRun: begin
            aq_q    <= aq_d;
            count_q <= count_q + 5'd1;
            if (count_q == 5'd31) state_q <= StDone;
          end
          StDone: begin
            result_q <= dz_q ? 32'd0 : quot;
            exc_q    <= dz_q;
            rdy_q    <= 1'b1;
            state_q  <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule
